apb_slave_param: RTL

- Parametrised, memory-backed APB4 completer replacing the fixed 8/16/32-bit slave variants behind the AXI-APB bridge.
- One module covers any native width (8/16/32) and depth, with base-address decode and programmable wait states.
- Byte-lane steering against a 32-bit bus, PSTRB masking, and PSLVERR on decode faults.
- Instantiated once per PSEL bit of the bridge.

---
 rtl/apb_slv_pkg.sv | 23 ++
 rtl/apb_slv_lane_steer.sv | 23 ++
 rtl/apb_slave_param.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and width helpers for the parametrised APB4 completer.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_e;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  // Bytes per storage entry.
  function automatic int lane_bytes(input int slv_width);
    return slv_width / 8;
  endfunction

  // Byte-offset to entry-index shift.
  function automatic int addr_shift(input int slv_width);
    return $clog2(slv_width / 8);
  endfunction

endpackage

// File: rtl/apb_slv_lane_steer.sv
// Byte-lane steering between the 32-bit APB bus and a narrower native entry.
module apb_slv_lane_steer
  import apb_slv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SLV_WIDTH  = 32
) (
  input  logic [1:0]              lane_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic [SLV_WIDTH-1:0]    rd_entry_i,
  output logic [SLV_WIDTH-1:0]    wr_data_o,
  output logic [SLV_WIDTH/8-1:0]  wr_be_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);
  localparam int NB = lane_bytes(SLV_WIDTH);

  // Shifting by the lane drops strobes outside the entry's lanes and zero-fills the rest.
  assign wr_data_o = SLV_WIDTH'(wdata_i >> {lane_i, 3'b000});
  assign wr_be_o   = NB'(strb_i >> lane_i);
  assign rd_data_o = DATA_WIDTH'(rd_entry_i) << {lane_i, 3'b000};

endmodule

// File: rtl/apb_slave_param.sv
// Memory-backed APB4 completer with base decode, wait states and lane steering.
// Optional macro APB_SLV_PROT_CHECK_EN: non-secure accesses to the upper half of storage fault.
module apb_slave_param
  import apb_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SLV_WIDTH   = 32,
  parameter int                    DEPTH       = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [2:0]              PPROT,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int                    NB         = lane_bytes(SLV_WIDTH);
  localparam int                    SHIFT      = addr_shift(SLV_WIDTH);
  localparam int                    IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(DEPTH * NB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

  apb_slv_state_e         state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q;
  logic                   err_q, write_q;
  logic [1:0]             lane_q;
  logic                   ready_q, slverr_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic [ADDR_WIDTH-1:0]  off;
  logic [IDX_W-1:0]       idx_dec;
  logic                   err_dec;
  logic                   prot_unused;
  logic                   capture, enter_rdy, commit, from_bus;
  logic [IDX_W-1:0]       acc_idx;
  logic                   acc_err, acc_write;
  logic [1:0]             acc_lane;
  logic [SLV_WIDTH-1:0]   mem_q [DEPTH];
  logic [SLV_WIDTH-1:0]   rd_entry, wr_data;
  logic [NB-1:0]          wr_be;
  logic [DATA_WIDTH-1:0]  rd_bus;

  assign off     = PADDR - BASE_ADDR;
  assign idx_dec = off[SHIFT +: IDX_W];
`ifdef APB_SLV_PROT_CHECK_EN
  assign err_dec = (off >= SPAN) || ((off & ALIGN_MASK) != '0) ||
                   (PPROT[1] && idx_dec[IDX_W-1]);
  assign prot_unused = PPROT[2] ^ PPROT[0];
`else
  assign err_dec = (off >= SPAN) || ((off & ALIGN_MASK) != '0);
  assign prot_unused = ^PPROT;
`endif

  // With no wait states the access completes on the setup edge, so decode feeds it directly.
  assign from_bus  = (state_q == IDLE);
  assign acc_idx   = from_bus ? idx_dec   : idx_q;
  assign acc_err   = from_bus ? err_dec   : err_q;
  assign acc_write = from_bus ? PWRITE    : write_q;
  assign acc_lane  = from_bus ? PADDR[1:0] : lane_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    enter_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d   = READY;
            enter_rdy = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d   = READY;
          cnt_d     = '0;
          enter_rdy = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      lane_q   <= '0;
      ready_q  <= 1'b0;
      slverr_q <= APB_RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= idx_dec;
        err_q   <= err_dec;
        write_q <= PWRITE;
        lane_q  <= PADDR[1:0];
      end
      ready_q  <= enter_rdy;
      slverr_q <= (enter_rdy && acc_err) ? APB_RESP_ERR : APB_RESP_OKAY;
      rdata_q  <= (enter_rdy && !acc_write && !acc_err) ? rd_bus : '0;
    end
  end

  // Gating with PRESETn keeps a reset that lands on the commit edge from writing.
  assign commit   = PRESETn && enter_rdy && acc_write && !acc_err;
  assign rd_entry = mem_q[acc_idx];

  always_ff @(posedge PCLK) begin
    if (commit) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) mem_q[acc_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
  end

  apb_slv_lane_steer #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLV_WIDTH  (SLV_WIDTH)
  ) u_steer (
    .lane_i     (acc_lane),
    .wdata_i    (PWDATA),
    .strb_i     (PSTRB),
    .rd_entry_i (rd_entry),
    .wr_data_o  (wr_data),
    .wr_be_o    (wr_be),
    .rd_data_o  (rd_bus)
  );

  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;
  assign PRDATA  = rdata_q;

endmodule
